// File: rtl/lcd_line_fifo.sv
// Line buffer feeding the LCD RGB pins: host pushes RGB565 words, the timing
// generator pops one pixel per DE cycle, and a refill FSM asks for one line at a time.
module lcd_line_fifo #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int LINE_WORDS = 800,
  parameter int REQ_LEVEL  = 800
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              WR_EN,
  input  logic [15:0]       WR_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   LEVEL,
  input  logic              LINE_START,
  input  logic              FRAME_START,
  input  logic              DE_IN,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  output logic              LCD_DE,
  output logic              LCD_HSYNC,
  output logic              LCD_VSYNC,
  output logic [4:0]        LCD_R,
  output logic [5:0]        LCD_G,
  output logic [4:0]        LCD_B,
  output logic              LINE_REQ,
  output logic              UNDERFLOW,
  input  logic              UNDERFLOW_CLR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LVL_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_REQ   = (ADDR_W+1)'(REQ_LEVEL);
  localparam logic [ADDR_W:0] LVL_LINE  = (ADDR_W+1)'(LINE_WORDS);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d, cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic              line_req_q, line_req_d;
  logic              underflow_q, underflow_d;
  logic [15:0]       rgb_q, rgb_d;
  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic              full, empty, wr_acc, pop, underrun;

  assign full  = (level_q == LVL_DEPTH);
  assign empty = (level_q == {(ADDR_W+1){1'b0}});

  // FIFO datapath: FRAME_START discards both sides; black is emitted whenever no pop happens.
  always_comb begin
    wr_acc   = WR_EN && !full && !FRAME_START;
    pop      = DE_IN && !empty && !FRAME_START;
    underrun = DE_IN && empty;
    if (FRAME_START) begin
      wr_ptr_d = {ADDR_W{1'b0}};
      rd_ptr_d = {ADDR_W{1'b0}};
      level_d  = {(ADDR_W+1){1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
      level_d  = level_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(pop);
    end
    if (pop) begin
      rgb_d = mem[rd_ptr_q];
    end else begin
      rgb_d = 16'h0000;
    end
    de_d = DE_IN;
    hs_d = HSYNC_IN;
    vs_d = VSYNC_IN;
    if (underrun) begin
      underflow_d = 1'b1;
    end else if (UNDERFLOW_CLR) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Refill FSM: one request per line, burst counted until a full line has arrived.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (FRAME_START) begin
      state_d = ST_IDLE;
      cnt_d   = {(ADDR_W+1){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (LINE_START && ((LVL_DEPTH - level_q) >= LVL_REQ)) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (wr_acc) begin
            cnt_d   = (ADDR_W+1)'(1);
            state_d = (LVL_LINE == (ADDR_W+1)'(1)) ? ST_IDLE : ST_FILL;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_FILL: begin
          if (wr_acc) begin
            cnt_d   = cnt_q + (ADDR_W+1)'(1);
            state_d = (cnt_d == LVL_LINE) ? ST_IDLE : ST_FILL;
          end else begin
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end
      endcase
    end
    line_req_d = (state_d == ST_REQ);
  end

  // Storage array; not reset, validity is tracked by the pointers.
  always_ff @(posedge PixelClk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= WR_DATA;
    end
  end

  // State registers with synchronous active-low reset; syncs idle high.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      level_q     <= {(ADDR_W+1){1'b0}};
      cnt_q       <= {(ADDR_W+1){1'b0}};
      state_q     <= ST_IDLE;
      line_req_q  <= 1'b0;
      underflow_q <= 1'b0;
      rgb_q       <= 16'h0000;
      de_q        <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      line_req_q  <= line_req_d;
      underflow_q <= underflow_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign FULL      = full;
  assign EMPTY     = empty;
  assign LEVEL     = level_q;
  assign LINE_REQ  = line_req_q;
  assign UNDERFLOW = underflow_q;
  assign LCD_DE    = de_q;
  assign LCD_HSYNC = hs_q;
  assign LCD_VSYNC = vs_q;
  assign LCD_R     = rgb_q[15:11];
  assign LCD_G     = rgb_q[10:5];
  assign LCD_B     = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_line_fifo.sv
// Directed bench for lcd_line_fifo: inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point, i.e. after the edge they reflect.
module tb_lcd_line_fifo;

  logic        clk = 1'b0;
  logic        nrst, wr_en, line_start, frame_start, de_in, hsync_in, vsync_in, uf_clr;
  logic [15:0] wr_data;
  logic        full, empty, lcd_de, lcd_hs, lcd_vs, line_req, underflow;
  logic [10:0] level;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lcd_line_fifo dut (
    .PixelClk(clk), .nRST(nrst), .WR_EN(wr_en), .WR_DATA(wr_data),
    .FULL(full), .EMPTY(empty), .LEVEL(level),
    .LINE_START(line_start), .FRAME_START(frame_start),
    .DE_IN(de_in), .HSYNC_IN(hsync_in), .VSYNC_IN(vsync_in),
    .LCD_DE(lcd_de), .LCD_HSYNC(lcd_hs), .LCD_VSYNC(lcd_vs),
    .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b),
    .LINE_REQ(line_req), .UNDERFLOW(underflow), .UNDERFLOW_CLR(uf_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = 16'h0000; line_start = 1'b0; frame_start = 1'b0;
    de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; uf_clr = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [15:0] rgb();
    return {lcd_r, lcd_g, lcd_b};
  endfunction

  initial begin
    idle_inputs();
    nrst = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rgb", 32'(rgb()), 32'd0);
    check_eq("rst_hs", 32'(lcd_hs), 32'd1);
    check_eq("rst_vs", 32'(lcd_vs), 32'd1);
    check_eq("rst_de", 32'(lcd_de), 32'd0);
    check_eq("rst_req", 32'(line_req), 32'd0);
    check_eq("rst_uf", 32'(underflow), 32'd0);

    // three primaries, popped back to back; syncs follow with one cycle delay
    push(16'hF800); push(16'h07E0); push(16'h001F);
    check_eq("lvl3", 32'(level), 32'd3);
    de_in = 1'b1; hsync_in = 1'b0;
    tick();
    check_eq("pix0_de", 32'(lcd_de), 32'd1);
    check_eq("pix0_r", 32'(lcd_r), 32'd31);
    check_eq("pix0_gb", 32'({lcd_g, lcd_b}), 32'd0);
    check_eq("pix0_hs", 32'(lcd_hs), 32'd0);
    hsync_in = 1'b1; vsync_in = 1'b0;
    tick();
    check_eq("pix1_g", 32'(lcd_g), 32'd63);
    check_eq("pix1_rb", 32'({lcd_r, lcd_b}), 32'd0);
    check_eq("pix1_hs", 32'(lcd_hs), 32'd1);
    check_eq("pix1_vs", 32'(lcd_vs), 32'd0);
    vsync_in = 1'b1;
    tick();
    check_eq("pix2_b", 32'(lcd_b), 32'd31);
    check_eq("pix2_de", 32'(lcd_de), 32'd1);
    de_in = 1'b0;
    tick();
    check_eq("post_de", 32'(lcd_de), 32'd0);
    check_eq("post_rgb", 32'(rgb()), 32'd0);
    check_eq("post_lvl", 32'(level), 32'd0);

    // underflow with a concurrent write: word stored, not passed through
    de_in = 1'b1; wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    idle_inputs();
    check_eq("uf_de", 32'(lcd_de), 32'd1);
    check_eq("uf_rgb", 32'(rgb()), 32'd0);
    check_eq("uf_set", 32'(underflow), 32'd1);
    check_eq("uf_lvl", 32'(level), 32'd1);
    uf_clr = 1'b1;
    tick();
    check_eq("uf_clr", 32'(underflow), 32'd0);
    uf_clr = 1'b0; de_in = 1'b1;
    tick();
    check_eq("uf_word_r", 32'(lcd_r), 32'd2);
    check_eq("uf_word_g", 32'(lcd_g), 32'd17);
    check_eq("uf_word_b", 32'(lcd_b), 32'd20);
    check_eq("uf_none", 32'(underflow), 32'd0);
    uf_clr = 1'b1;
    tick();
    check_eq("uf_prio", 32'(underflow), 32'd1);
    idle_inputs(); uf_clr = 1'b1;
    tick();
    uf_clr = 1'b0;
    check_eq("uf_clr2", 32'(underflow), 32'd0);

    // one-line refill burst
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_eq("req_rise", 32'(line_req), 32'd1);
    tick();
    check_eq("req_hold", 32'(line_req), 32'd1);
    push(16'd0);
    check_eq("req_drop", 32'(line_req), 32'd0);
    for (int i = 1; i < 800; i++) push(16'(i));
    check_eq("burst_lvl", 32'(level), 32'd800);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check_eq("no_req_224", 32'(line_req), 32'd0);

    // fill to DEPTH, then a write against FULL with a simultaneous pop
    for (int i = 800; i < 1024; i++) push(16'(i));
    check_eq("full", 32'(full), 32'd1);
    check_eq("full_lvl", 32'(level), 32'd1024);
    wr_en = 1'b1; wr_data = 16'hFFFF; de_in = 1'b1;
    tick();
    wr_en = 1'b0;
    check_eq("drop_lvl", 32'(level), 32'd1023);
    check_eq("drop_de", 32'(lcd_de), 32'd1);
    check_eq("drop_full", 32'(full), 32'd0);
    for (int k = 1; k < 1024; k++) begin
      tick();
      check_eq($sformatf("drain%0d", k), 32'(rgb()), 32'(k));
    end
    de_in = 1'b0;
    tick();
    check_eq("drain_empty", 32'(empty), 32'd1);
    check_eq("drain_uf", 32'(underflow), 32'd0);

    // FSM is back in IDLE: a new request issues
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_eq("req_again", 32'(line_req), 32'd1);

    // FRAME_START mid-burst together with a write and a pop
    for (int i = 0; i < 400; i++) push(16'(16'h4000 + i));
    check_eq("mid_lvl", 32'(level), 32'd400);
    check_eq("mid_req", 32'(line_req), 32'd0);
    frame_start = 1'b1; wr_en = 1'b1; wr_data = 16'hABCD; de_in = 1'b1;
    tick();
    idle_inputs();
    check_eq("fs_lvl", 32'(level), 32'd0);
    check_eq("fs_empty", 32'(empty), 32'd1);
    check_eq("fs_req", 32'(line_req), 32'd0);
    check_eq("fs_de", 32'(lcd_de), 32'd1);
    check_eq("fs_rgb", 32'(rgb()), 32'd0);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_eq("fs_idle_req", 32'(line_req), 32'd1);
    push(16'h5A5A);
    de_in = 1'b1;
    tick();
    de_in = 1'b0;
    check_eq("fs_next_word", 32'(rgb()), 32'h5A5A);

    // reset with content and an outstanding request
    push(16'h1111);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check_eq("rst2_lvl", 32'(level), 32'd0);
    check_eq("rst2_req", 32'(line_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
